// File: rtl/sdil_pkg.sv
// Shared definitions for the serial block deinterleaver: default frame
// geometry, the per-bank state enum and the (row, col) -> bit index map.
package sdil_pkg;

  localparam int unsigned SDIL_ROWS = 5;
  localparam int unsigned SDIL_COLS = 7;

  // Life cycle of one frame buffer.
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Row-major position of the bit at row r, column c.
  function automatic int unsigned rc_to_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/sdil_bank.sv
// One N-bit frame buffer. Supports a whole-frame clear, a single-bit write
// at an arbitrary index and tracks EMPTY/FILLING/FULL. The state is
// exported on state_o so checkers can observe each bank directly.
module sdil_bank
  import sdil_pkg::*;
#(
  parameter int unsigned N     = 35,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,    // discard partial frame (same-cycle write still lands)
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_bit_i,
  input  logic             last_i,     // this write completes the frame
  input  logic             rd_done_i,  // consumer has taken the frame
  output logic [N-1:0]     data_o,
  output bank_state_e      state_o
);

  logic [N-1:0] data_q, data_d;
  bank_state_e  state_q, state_d;

  // Next frame contents and bank state.
  always_comb begin
    data_d  = data_q;
    state_d = state_q;
    if (clear_i) begin
      data_d = '0;
    end
    if (wr_en_i) begin
      data_d[wr_idx_i] = wr_bit_i;
    end
    case (state_q)
      BANK_EMPTY: begin
        if (wr_en_i) begin
          state_d = last_i ? BANK_FULL : BANK_FILLING;
        end
      end
      BANK_FILLING: begin
        if (wr_en_i && last_i) begin
          state_d = BANK_FULL;
        end
      end
      BANK_FULL: begin
        if (rd_done_i) begin
          state_d = BANK_EMPTY;
        end
      end
      default: state_d = BANK_EMPTY;
    endcase
  end

  // Frame storage and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      state_q <= BANK_EMPTY;
    end else begin
      data_q  <= data_d;
      state_q <= state_d;
    end
  end

  assign data_o  = data_q;
  assign state_o = state_q;

endmodule

// File: rtl/serial_deinterleaver.sv
// Receive-side block deinterleaver. Bits arrive column-major (k -> row k%ROWS,
// col k/ROWS) and are stored row-major so each completed frame is presented
// as one parallel word. Two banks ping-pong so a frame can fill while the
// previous one waits for the consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid in the same cycle, and a presented
// frame (out_valid high) stays unchanged until out_ready takes it.
//
// Optional feature: define SDIL_FRAME_CNT_EN to add the 16-bit frame_cnt
// output counting delivered frames.
module serial_deinterleaver
  import sdil_pkg::*;
#(
  parameter int unsigned ROWS = SDIL_ROWS,
  parameter int unsigned COLS = SDIL_COLS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_bit,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [ROWS*COLS-1:0]   out_data,
  input  logic                   out_ready
`ifdef SDIL_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;

  logic [RW-1:0]    r_q, r_d, base_r;
  logic [CW-1:0]    c_q, c_d, base_c;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic             accept, rd_fire, restart, wr_last;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_hit, rd_hit;

  logic [N-1:0]     bank_data  [2];
  bank_state_e      bank_state [2];

  assign in_ready  = (bank_state[wr_sel_q] != BANK_FULL);
  assign out_valid = (bank_state[rd_sel_q] == BANK_FULL);
  assign out_data  = bank_data[rd_sel_q];

  assign accept  = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  // Start-of-frame only matters when something has already been written.
  assign restart = accept & in_sof & ((r_q != '0) | (c_q != '0));

  assign wr_hit = wr_sel_q ? 2'b10 : 2'b01;
  assign rd_hit = rd_sel_q ? 2'b10 : 2'b01;

  // Write pointer and bank select: in_sof rebases the pointer to k = 0 before
  // the write; the last bit of a frame wraps the pointer and flips banks.
  always_comb begin
    base_r   = in_sof ? '0 : r_q;
    base_c   = in_sof ? '0 : c_q;
    wr_idx   = IDX_W'(rc_to_idx(32'(base_r), 32'(base_c), COLS));
    wr_last  = (base_r == RW'(ROWS - 1)) && (base_c == CW'(COLS - 1));
    r_d      = r_q;
    c_d      = c_q;
    wr_sel_d = wr_sel_q;
    if (accept) begin
      if (wr_last) begin
        r_d      = '0;
        c_d      = '0;
        wr_sel_d = ~wr_sel_q;
      end else if (base_r == RW'(ROWS - 1)) begin
        r_d = '0;
        c_d = base_c + 1'b1;
      end else begin
        r_d = base_r + 1'b1;
        c_d = base_c;
      end
    end
    rd_sel_d = rd_sel_q ^ rd_fire;
  end

  // Pointer and select registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q      <= '0;
      c_q      <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      r_q      <= r_d;
      c_q      <= c_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    sdil_bank #(
      .N     (N),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst),
      .clear_i   (restart & wr_hit[i]),
      .wr_en_i   (accept & wr_hit[i]),
      .wr_idx_i  (wr_idx),
      .wr_bit_i  (in_bit),
      .last_i    (wr_last),
      .rd_done_i (rd_fire & rd_hit[i]),
      .data_o    (bank_data[i]),
      .state_o   (bank_state[i])
    );
  end

`ifdef SDIL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Delivered-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (rd_fire) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/serial_deinterleaver.md
# serial_deinterleaver

Receive-side block deinterleaver for the bit-serial channel. It accepts one channel bit per handshake in column-major (transmit) order and rebuilds each ROWS×COLS frame in its original row-major order. It presents each completed frame as one parallel word with a valid/ready handshake. Frames are double-buffered, so a frame can fill while the previous one waits to be read.

## Interface
- ROWS, default 5: interleaver rows.
- COLS, default 7: interleaver columns. N = ROWS*COLS = 35 is the frame width.
- clk  input  1  clock. All logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial channel bit.
- in_sof  input  1  start of frame; qualified by in_valid.
- in_ready  output  1  block can accept a bit this cycle.
- out_valid  output  1  out_data holds a complete frame.
- out_data  output  N  deinterleaved frame; bit j is original bit j.
- out_ready  input  1  consumer takes the frame this cycle.
- frame_cnt  output  16  frames delivered (only with SDIL_FRAME_CNT_EN).

## Operation
- Accept: in_valid & in_ready on a rising edge.
- Serial index k = 0..N-1 is split into column c = k / ROWS and row r = k % ROWS. The accepted bit is written to bank bit r*COLS + c.
- Write pointer: row counter r (0..ROWS-1) and column counter c (0..COLS-1). r advances on every accept. When r wraps, c advances. No divider is used.
- Two banks, each with state EMPTY, FILLING or FULL.
  - wr_sel selects the bank being written.
  - rd_sel selects the bank being presented.
- Accept at k = N-1: the write bank goes FULL, wr_sel toggles and the pointer returns to 0.
- Frames are presented strictly in completion order.
- in_ready = 1 when bank[wr_sel] is not FULL.
- out_valid = 1 when bank[rd_sel] is FULL.
- out_data = contents of bank[rd_sel].
- out_valid & out_ready: bank[rd_sel] becomes EMPTY and rd_sel toggles.
- in_sof with an accept:
  - The pointer is forced to k = 0 and the bit is written at index 0.
  - Bits already written to the current bank are discarded; the bank restarts FILLING.
  - A FULL bank is never touched.
- in_sof at k = 0 has no special effect.
- Without in_sof, framing free-runs every N accepted bits.
- Simultaneous events:
  - Completing bank A while bank B is read in the same cycle is legal; in_ready stays 1.
  - A read and a write on different banks never conflict. The write bank is never the FULL read bank.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, in_ready = 1.
  - Both banks EMPTY and zeroed; wr_sel = rd_sel = 0; pointer = 0; frame_cnt = 0.
- Reset asserted mid-frame discards all partial and full frames immediately (asynchronous).
- Latency: out_valid rises the cycle after the edge that accepts bit k = N-1.
  - With both banks empty, that is N+1 cycles after the first accept at full rate.
- out_data is stable while out_valid = 1 and out_ready = 0.
- Sustained throughput is 1 bit/cycle while out_ready keeps pace. Consumer read latency is hidden by the second bank.
- in_ready falls in the cycle after the second bank completes while the first is unread. It rises in the cycle after a read frees a bank.

## Configuration
- SDIL_FRAME_CNT_EN defined:
  - Adds the frame_cnt port.
  - frame_cnt increments on every out_valid & out_ready and wraps 0xFFFF -> 0.
  - Resets to 0.
- Undefined: no frame_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Package sdil_pkg holds:
  - default ROWS/COLS constants;
  - the bank-state enum (EMPTY/FILLING/FULL);
  - a function mapping (r, c) to the row-major index.
- Sub-module sdil_bank: one N-bit frame buffer with clear, single-bit write at index, and state. The top instantiates two of them plus pointer and select logic.

## Test plan
- Let D = 35'b00010100011111000011110110111100101. Serial bit k = D[(k%5)*7 + k/5], sent with in_sof at k = 0 and out_ready = 1.
  - Required: out_valid high exactly 1 cycle after the 35th accept, out_data = D, frame_cnt = 1.
- Three D frames back-to-back with out_ready = 0.
  - Required: in_ready = 1 for 70 accepts, then low.
  - Raise out_ready for 1 cycle: out_data = D, in_ready returns the next cycle.
- 10 bits of garbage, then in_sof with frame D.
  - Required: one output frame, equal to D; the garbage never appears.
- Complete bank 0, then hold out_ready = 1 while bank 1's last bit is accepted in the read cycle.
  - Required: no stall, in_ready stays 1, frames come out in order.
- Assert rst low after 20 bits, release, then send D.
  - Required: out_valid = 0 and out_data = 0 during reset; the next frame equals D.
- Gap in_valid randomly (50 % duty) across frame D.
  - Required: out_data = D; out_valid is held with data stable until out_ready.
